fwd_scoreboard_unit: RTL and testbench
======================================

Name: fwd_scoreboard_unit

Overview:
- Parametrised successor to the two-source forwarding unit.
- Owns an internal tag pipeline recording destination, write-back and load status of the DEPTH instructions ahead of the EX-stage consumer.
- Selects per-operand forwarded data from NUM_SRC sources and raises a load-use stall, inserting a bubble into its own tag pipeline.
- Sits between the ID/EX pipe register and the ALU operand inputs.

Parameters:
DATA_W, 16, operand/result width
ADDR_W, 3, register address width
NUM_SRC, 2, number of source operands per instruction
DEPTH, 2, tracked producer stages; tag[0] is the instruction immediately ahead of EX
LOAD_LAT, 1, load result unavailable while its tag index < LOAD_LAT (range 1..DEPTH-1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX-stage instruction valid
ex_flush  in  1  kill EX-stage instruction
ex_src_addr  in  NUM_SRC*ADDR_W  source register addresses, operand i at bits [i*ADDR_W +: ADDR_W]
ex_src_used  in  NUM_SRC  operand i actually read
ex_read_data  in  NUM_SRC*DATA_W  register-file values from ID/EX
ex_dst_addr  in  ADDR_W  EX instruction destination
ex_wb  in  1  EX instruction writes back
ex_is_load  in  1  EX instruction is a load
stage_data  in  DEPTH*DATA_W  result carried by tag[k]'s instruction this cycle
ex_operand  out  NUM_SRC*DATA_W  operands to ALU
fwd_sel  out  NUM_SRC*2  per operand: 2'b11 register file, 2'b00 tag[0], 2'b01 tag[1], 2'b10 tag[2+]
fwd_idx  out  NUM_SRC*$clog2(DEPTH+1)  matched tag index; DEPTH = none
stall  out  1  hold PC, IF/ID, ID/EX

Behaviour:
- Reset (async, rst_n=0): all tag valid bits 0. Stall FSM in RUN. Outputs then: stall=0, fwd_sel=all 11, ex_operand=ex_read_data.
- Tag entry fields: valid, dst, wb, is_load.
- Match for operand i at index k: ex_valid & ~ex_flush & ex_src_used[i] & tag[k].valid & tag[k].wb & tag[k].dst==src_i.
- Lowest matching k (youngest) wins.
- No match: operand = ex_read_data slice.
- Forwarding path (ex_operand, fwd_sel, fwd_idx) is combinational, zero latency.
- Load-use: any operand whose winning match k has tag[k].is_load & k<LOAD_LAT asserts stall combinationally. Lower non-load matches still take priority.
- Clock edge, no stall:
  - tag[k+1] <= tag[k].
  - tag[0] <= {ex_valid & ~ex_flush, ex_dst_addr, ex_wb, ex_is_load}.
- Clock edge, stall:
  - tag[k+1] <= tag[k].
  - tag[0] <= bubble (valid=0).
  - Consumer is held by the datapath and re-evaluated next cycle with the producer one index further.
- Oldest entry tag[DEPTH-1] is discarded on every edge.
- Stall FSM:
  - RUN -> HOLD on stall. HOLD counts stall cycles.
  - HOLD -> RUN when stall deasserts.
  - Consecutive stall cycles never exceed LOAD_LAT, guaranteed by the bubble shifting. Exceeding it is a design error, flagged in simulation by an assertion.
- ex_flush takes priority over stall: stall=0, bubble pushed.
- Same register in several tags: youngest wins.
- Both operands naming the same register: each resolves independently to the same source.
- rst_n asserted mid-stall: tags and FSM cleared immediately; stall drops in the same cycle.

Optional Feature:
- Macro FWD_STATS_EN.
- When defined, two extra outputs:
  - fwd_count [15:0]: increments by 1 per cycle where any operand forwards.
  - stall_count [15:0]: increments by 1 per stall cycle.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined: ports and counters absent; the forwarding path is identical in both builds.

Test Plan:
- Reset: rst_n=0 with tags holding valid writers -> stall=0, fwd_sel=11/11, ex_operand=ex_read_data. Release reset and present a src matching the old dst -> still no forward.
- ALU back-to-back: push dst=r2 wb=1; next cycle src0=r2, stage_data[0]=16'h1234 -> ex_operand[0]=1234, fwd_sel[0]=00, stall=0.
- Priority: tag[0] and tag[1] both dst=r4, data 16'hAAAA and 16'h5555, src1=r4 -> operand1=AAAA. Set tag[0].wb=0 -> operand1=5555, fwd_sel=01.
- Load-use: load dst=r1, then consumer src0=r1 -> stall=1 for exactly 1 cycle, bubble in tag[0]. Next cycle operand0=stage_data[1]=16'hBEEF, fwd_sel=01, stall=0.
- Flush/unused: ex_flush=1 during a load-use match -> stall=0 and tag[0] invalid next cycle. ex_src_used=0 with a matching address -> fwd_sel=11.
- FWD_STATS_EN build: 3 forwarding cycles plus 1 stall -> fwd_count=3, stall_count=1. Preload 16'hFFFF -> stays FFFF.

Source files
------------

// File: rtl/fwd_scoreboard_unit.sv
// Operand forwarding with an internal producer tag pipeline and load-use stall; zero-latency forward path.
// Optional FWD_STATS_EN adds saturating forward/stall cycle counters.
module fwd_scoreboard_unit #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  localparam int IDX_W   = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ex_valid,
  input  logic                        ex_flush,
  input  logic [NUM_SRC*ADDR_W-1:0]   ex_src_addr,
  input  logic [NUM_SRC-1:0]          ex_src_used,
  input  logic [NUM_SRC*DATA_W-1:0]   ex_read_data,
  input  logic [ADDR_W-1:0]           ex_dst_addr,
  input  logic                        ex_wb,
  input  logic                        ex_is_load,
  input  logic [DEPTH*DATA_W-1:0]     stage_data,
  output logic [NUM_SRC*DATA_W-1:0]   ex_operand,
  output logic [NUM_SRC*2-1:0]        fwd_sel,
  output logic [NUM_SRC*IDX_W-1:0]    fwd_idx,
  output logic                        stall
`ifdef FWD_STATS_EN
  ,
  output logic [15:0]                 fwd_count,
  output logic [15:0]                 stall_count
`endif
);

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] dst;
    logic              wb;
    logic              ld;
  } tag_t;

  typedef enum logic {RUN, HOLD} state_t;

  tag_t               tag_q [DEPTH];
  logic               live;
  logic [NUM_SRC-1:0] fwd_hit;
  logic [NUM_SRC-1:0] lu_hit;
  logic [DATA_W-1:0]  win_dat [NUM_SRC];
  logic [1:0]         win_sel [NUM_SRC];
  logic [IDX_W-1:0]   win_idx [NUM_SRC];

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   hold_q, hold_d;
  logic               in_hold;

  assign live = ex_valid & ~ex_flush;

  // Scan oldest to youngest so the lowest matching index is the one that sticks.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_hit[i] = 1'b0;
      lu_hit[i]  = 1'b0;
      win_dat[i] = '0;
      win_sel[i] = 2'b11;
      win_idx[i] = IDX_W'(DEPTH);
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (live && ex_src_used[i] && tag_q[k].vld && tag_q[k].wb &&
            tag_q[k].dst == ex_src_addr[i*ADDR_W +: ADDR_W]) begin
          fwd_hit[i] = 1'b1;
          lu_hit[i]  = tag_q[k].ld && (k < LOAD_LAT);
          win_dat[i] = stage_data[k*DATA_W +: DATA_W];
          win_sel[i] = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b10;
          win_idx[i] = IDX_W'(k);
        end
      end
    end
  end

  always_comb begin
    ex_operand = ex_read_data;
    fwd_sel    = '1;
    fwd_idx    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (fwd_hit[i]) ex_operand[i*DATA_W +: DATA_W] = win_dat[i];
      fwd_sel[i*2 +: 2]         = win_sel[i];
      fwd_idx[i*IDX_W +: IDX_W] = win_idx[i];
    end
  end

  assign stall = |lu_hit;

  // A stalled consumer leaves a bubble behind so the load advances one index per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) tag_q[k] <= '0;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) tag_q[k] <= tag_q[k-1];
      tag_q[0] <= stall ? tag_t'('0) : tag_t'{live, ex_dst_addr, ex_wb, ex_is_load};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      RUN: if (stall) begin
        state_d = HOLD;
        hold_d  = IDX_W'(1);
      end
      HOLD: if (stall) begin
        hold_d = hold_q + 1'b1;
      end else begin
        state_d = RUN;
        hold_d  = '0;
      end
      default: begin
        state_d = RUN;
        hold_d  = '0;
      end
    endcase
  end

  always_comb begin
    in_hold = (state_q == HOLD);
  end

  // hold_q counts stall cycles already taken; one more beyond LOAD_LAT means the bubble failed.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(stall && in_hold && hold_q >= IDX_W'(LOAD_LAT)));

`ifdef FWD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_count   <= '0;
      stall_count <= '0;
    end else begin
      if (|fwd_hit && fwd_count != 16'hFFFF)  fwd_count   <= fwd_count + 16'd1;
      if (stall && stall_count != 16'hFFFF)   stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Directed vectors for fwd_scoreboard_unit; a monitor pops queued expectations at each falling edge.
module tb_fwd_scoreboard_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_flush = 1'b0;
  logic [5:0]  ex_src_addr = '0;
  logic [1:0]  ex_src_used = '0;
  logic [31:0] ex_read_data = {16'h0B0B, 16'h0A0A};
  logic [2:0]  ex_dst_addr = '0;
  logic        ex_wb = 1'b0;
  logic        ex_is_load = 1'b0;
  logic [31:0] stage_data = '0;
  logic [31:0] ex_operand;
  logic [3:0]  fwd_sel;
  logic [3:0]  fwd_idx;
  logic        stall;
`ifdef FWD_STATS_EN
  logic [15:0] fwd_count;
  logic [15:0] stall_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [40:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  fwd_scoreboard_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_flush     (ex_flush),
    .ex_src_addr  (ex_src_addr),
    .ex_src_used  (ex_src_used),
    .ex_read_data (ex_read_data),
    .ex_dst_addr  (ex_dst_addr),
    .ex_wb        (ex_wb),
    .ex_is_load   (ex_is_load),
    .stage_data   (stage_data),
    .ex_operand   (ex_operand),
    .fwd_sel      (fwd_sel),
    .fwd_idx      (fwd_idx),
    .stall        (stall)
`ifdef FWD_STATS_EN
    ,
    .fwd_count    (fwd_count),
    .stall_count  (stall_count)
`endif
  );

  task automatic drive(input logic rst, input logic vld, input logic fl,
                       input logic [2:0] s0, input logic [2:0] s1, input logic [1:0] used,
                       input logic [2:0] dst, input logic wb, input logic ld,
                       input logic [15:0] sd0, input logic [15:0] sd1,
                       input logic [15:0] e0, input logic [15:0] e1,
                       input logic [3:0] esel, input logic [3:0] eidx, input logic est,
                       input string nm);
    @(posedge clk);
    #1;
    rst_n       = rst;
    ex_valid    = vld;
    ex_flush    = fl;
    ex_src_addr = {s1, s0};
    ex_src_used = used;
    ex_dst_addr = dst;
    ex_wb       = wb;
    ex_is_load  = ld;
    stage_data  = {sd1, sd0};
    exp_q.push_back({e1, e0, esel, eidx, est});
    name_q.push_back(nm);
  endtask

  initial begin : monitor
    logic [40:0] act;
    logic [40:0] exp;
    string       nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {ex_operand, fwd_sel, fwd_idx, stall};
        vectors++;
        if (act !== exp) begin
          miscompares++;
          $display("FAIL %s: got op=%h sel=%b idx=%b stall=%b, want op=%h sel=%b idx=%b stall=%b",
                   nm, act[40:9], act[8:5], act[4:1], act[0], exp[40:9], exp[8:5], exp[4:1], exp[0]);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (2) @(posedge clk);
    //     rst v  fl s0 s1 used dst wb ld sd0       sd1       e0        e1        sel      idx      st
    drive(1, 1, 0, 5, 6, 2'b11, 3, 1, 0, 16'hD0D0, 16'hD1D1, 16'h0A0A, 16'h0B0B, 4'b1111, 4'b1010, 0, "reset_state");
    drive(1, 1, 0, 7, 7, 2'b11, 5, 1, 0, 16'hD0D0, 16'hD1D1, 16'h0A0A, 16'h0B0B, 4'b1111, 4'b1010, 0, "fill_tags");
    drive(0, 1, 0, 5, 3, 2'b11, 0, 0, 0, 16'hD0D0, 16'hD1D1, 16'h0A0A, 16'h0B0B, 4'b1111, 4'b1010, 0, "reset_clears_tags");
    drive(1, 1, 0, 5, 3, 2'b11, 0, 0, 0, 16'hD0D0, 16'hD1D1, 16'h0A0A, 16'h0B0B, 4'b1111, 4'b1010, 0, "reset_release");
    drive(1, 1, 0, 6, 6, 2'b11, 2, 1, 0, 16'hD0D0, 16'hD1D1, 16'h0A0A, 16'h0B0B, 4'b1111, 4'b1010, 0, "push_r2");
    drive(1, 1, 0, 2, 7, 2'b11, 4, 1, 0, 16'h1234, 16'hD1D1, 16'h1234, 16'h0B0B, 4'b1100, 4'b1000, 0, "alu_back_to_back");
    drive(1, 1, 0, 6, 2, 2'b11, 4, 1, 0, 16'hD0D0, 16'hD1D1, 16'h0A0A, 16'hD1D1, 4'b0111, 4'b0110, 0, "fwd_tag1");
    drive(1, 1, 0, 7, 4, 2'b11, 4, 0, 0, 16'hAAAA, 16'h5555, 16'h0A0A, 16'hAAAA, 4'b0011, 4'b0010, 0, "priority_youngest");
    drive(1, 1, 0, 4, 4, 2'b11, 1, 1, 1, 16'hAAAA, 16'h5555, 16'h5555, 16'h5555, 4'b0101, 4'b0101, 0, "priority_wb0_both_ops");
    drive(1, 1, 0, 1, 6, 2'b11, 3, 1, 0, 16'h1111, 16'hD1D1, 16'h1111, 16'h0B0B, 4'b1100, 4'b1000, 1, "load_use_stall");
    drive(1, 1, 0, 1, 6, 2'b11, 3, 1, 0, 16'h1111, 16'hBEEF, 16'hBEEF, 16'h0B0B, 4'b1101, 4'b1001, 0, "load_use_resolved");
    drive(1, 1, 0, 1, 3, 2'b11, 1, 1, 1, 16'h3333, 16'hD1D1, 16'h0A0A, 16'h3333, 4'b0011, 4'b0010, 0, "bubble_in_tag1");
    drive(1, 1, 1, 1, 3, 2'b11, 5, 1, 0, 16'h2222, 16'hD1D1, 16'h0A0A, 16'h0B0B, 4'b1111, 4'b1010, 0, "flush_over_stall");
    drive(1, 1, 0, 5, 1, 2'b11, 2, 1, 0, 16'hD0D0, 16'h7777, 16'h0A0A, 16'h7777, 4'b0111, 4'b0110, 0, "flushed_tag_invalid");
    drive(1, 1, 0, 2, 2, 2'b00, 1, 1, 1, 16'hD0D0, 16'hD1D1, 16'h0A0A, 16'h0B0B, 4'b1111, 4'b1010, 0, "src_unused");
    drive(1, 1, 0, 1, 2, 2'b01, 1, 1, 1, 16'h4444, 16'hD1D1, 16'h4444, 16'h0B0B, 4'b1100, 4'b1000, 1, "stall_before_reset");
    @(negedge clk);
    #1 rst_n = 1'b0;
    drive(0, 1, 0, 1, 2, 2'b01, 1, 1, 1, 16'h4444, 16'hD1D1, 16'h0A0A, 16'h0B0B, 4'b1111, 4'b1010, 0, "reset_mid_stall");
    drive(1, 1, 0, 1, 2, 2'b01, 1, 1, 1, 16'h4444, 16'hD1D1, 16'h0A0A, 16'h0B0B, 4'b1111, 4'b1010, 0, "after_reset");
`ifdef FWD_STATS_EN
    drive(1, 1, 0, 6, 6, 2'b11, 2, 1, 0, 16'hD0D0, 16'hD1D1, 16'h0A0A, 16'h0B0B, 4'b1111, 4'b1010, 0, "stats_push");
    drive(1, 1, 0, 2, 6, 2'b01, 1, 1, 1, 16'h1234, 16'hD1D1, 16'h1234, 16'h0B0B, 4'b1100, 4'b1000, 0, "stats_fwd");
    drive(1, 1, 0, 1, 6, 2'b01, 3, 1, 0, 16'h5678, 16'hD1D1, 16'h5678, 16'h0B0B, 4'b1100, 4'b1000, 1, "stats_stall");
    drive(1, 1, 0, 1, 6, 2'b01, 3, 1, 0, 16'h5678, 16'h9ABC, 16'h9ABC, 16'h0B0B, 4'b1101, 4'b1001, 0, "stats_resolved");
    drive(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 16'hD0D0, 16'hD1D1, 16'h0A0A, 16'h0B0B, 4'b1111, 4'b1010, 0, "stats_idle");
    vectors++;
    if (fwd_count !== 16'd3) begin
      miscompares++;
      $display("FAIL fwd_count: got %0d, want 3", fwd_count);
    end
    vectors++;
    if (stall_count !== 16'd1) begin
      miscompares++;
      $display("FAIL stall_count: got %0d, want 1", stall_count);
    end
`endif
    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
